// File: rtl/adc_discr_align_ctrl.sv
// Link-training controller: pulses deserializer io_reset/bitslip until every lane shows its
// training pattern for MATCH_COUNT cycles. Define DISCR_ALIGN_EN to also train the discr lane.
module adc_discr_align_ctrl #(
   parameter logic [11:0] TRAIN_PATTERN   = 12'h3F0,
   parameter logic [7:0]  DISCR_PATTERN   = 8'hF0,
   parameter int unsigned IO_RESET_CYCLES = 4,
   parameter int unsigned SETTLE_CYCLES   = 8,
   parameter int unsigned MATCH_COUNT     = 16,
   parameter int unsigned MAX_SLIPS       = 6
) (
   input  logic        lclk,
   input  logic        rst,
   input  logic        start,
   input  logic [11:0] adc_bits,
   input  logic [7:0]  discr_bits,
   output logic [1:0]  adc_io_reset,
   output logic [1:0]  adc_bitslip,
   output logic        discr_io_reset,
   output logic        discr_bitslip,
   output logic        busy,
   output logic        locked,
   output logic        fail,
   output logic [2:0]  fail_lane,
   output logic [2:0]  slip_count_0,
   output logic [2:0]  slip_count_1
);

`ifdef DISCR_ALIGN_EN
   localparam logic [2:0] LANE_EN = 3'b111;
`else
   localparam logic [2:0] LANE_EN = 3'b011;
`endif
   localparam logic [2:0]  SLIP_MAX    = 3'(MAX_SLIPS);
   localparam logic [15:0] IORST_LAST  = 16'(IO_RESET_CYCLES - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] MATCH_LAST  = 16'(MATCH_COUNT - 1);

   typedef enum logic [2:0] {
      StIdle, StIoRst, StSettle, StCheck, StSlip, StLocked, StFail
   } state_e;

   state_e          state_q, state_d;
   logic [15:0]     timer_q, timer_d;
   logic [15:0]     match_q, match_d;
   logic [2:0]      mask_q, mask_d;
   logic [2:0]      fail_lane_q, fail_lane_d;
   logic [2:0][2:0] slip_q, slip_d;
   logic [2:0]      miss;
   logic [2:0]      exhausted;

   // Lanes not being trained never report a mismatch, so they never slip or fail.
   assign miss = LANE_EN & {discr_bits != DISCR_PATTERN,
                            adc_bits[11:6] != TRAIN_PATTERN[11:6],
                            adc_bits[5:0] != TRAIN_PATTERN[5:0]};

   always_comb begin
      exhausted = '0;
      for (int i = 0; i < 3; i++) begin
         exhausted[i] = miss[i] && (slip_q[i] == SLIP_MAX);
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      match_d     = match_q;
      mask_d      = mask_q;
      fail_lane_d = fail_lane_q;
      slip_d      = slip_q;
      unique case (state_q)
         StIdle, StLocked, StFail: begin
            if (start) begin
               state_d     = StIoRst;
               timer_d     = '0;
               match_d     = '0;
               mask_d      = '0;
               fail_lane_d = '0;
               slip_d      = '0;
            end
         end
         StIoRst: begin
            if (timer_q == IORST_LAST) begin
               state_d = StSettle;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         StSettle: begin
            if (timer_q == SETTLE_LAST) begin
               state_d = StCheck;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         StCheck: begin
            if (miss == '0) begin
               match_d = match_q + 16'd1;
               if (match_q == MATCH_LAST) state_d = StLocked;
            end else begin
               match_d = '0;
               if (exhausted != '0) begin
                  state_d     = StFail;
                  fail_lane_d = exhausted;
               end else begin
                  state_d = StSlip;
                  mask_d  = miss;
               end
            end
         end
         StSlip: begin
            for (int i = 0; i < 3; i++) begin
               if (mask_q[i] && slip_q[i] != SLIP_MAX) slip_d[i] = slip_q[i] + 3'd1;
            end
            state_d = StSettle;
            timer_d = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge lclk) begin
      if (rst) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         match_q     <= '0;
         mask_q      <= '0;
         fail_lane_q <= '0;
         slip_q      <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         match_q     <= match_d;
         mask_q      <= mask_d;
         fail_lane_q <= fail_lane_d;
         slip_q      <= slip_d;
      end
   end

   assign adc_io_reset   = {2{state_q == StIoRst}};
   assign discr_io_reset = LANE_EN[2] && (state_q == StIoRst);
   assign adc_bitslip    = (state_q == StSlip) ? mask_q[1:0] : 2'b00;
   assign discr_bitslip  = (state_q == StSlip) && mask_q[2];
   assign busy           = (state_q == StIoRst) || (state_q == StSettle) ||
                           (state_q == StCheck) || (state_q == StSlip);
   assign locked         = (state_q == StLocked);
   assign fail           = (state_q == StFail);
   assign fail_lane      = fail_lane_q;
   assign slip_count_0   = slip_q[0];
   assign slip_count_1   = slip_q[1];

endmodule

// File: tb/tb_adc_discr_align_ctrl.sv
// Directed bench for adc_discr_align_ctrl with a rotating-lane deserializer model and a
// scoreboard of per-run outcomes. Define DISCR_ALIGN_EN to include the discriminator case.
module tb_adc_discr_align_ctrl;
   logic        lclk = 1'b0;
   logic        rst, start;
   logic [11:0] adc_bits;
   logic [7:0]  discr_bits;
   logic [1:0]  adc_io_reset, adc_bitslip;
   logic        discr_io_reset, discr_bitslip, busy, locked, fail;
   logic [2:0]  fail_lane, slip_count_0, slip_count_1;

   always #5 lclk = ~lclk;

   adc_discr_align_ctrl dut (
      .lclk(lclk), .rst(rst), .start(start), .adc_bits(adc_bits), .discr_bits(discr_bits),
      .adc_io_reset(adc_io_reset), .adc_bitslip(adc_bitslip),
      .discr_io_reset(discr_io_reset), .discr_bitslip(discr_bitslip), .busy(busy),
      .locked(locked), .fail(fail), .fail_lane(fail_lane),
      .slip_count_0(slip_count_0), .slip_count_1(slip_count_1)
   );

`ifdef DISCR_ALIGN_EN
   localparam int DIOR = 4;
`else
   localparam int DIOR = 0;
`endif

   typedef struct {
      int lock; int fl; int fail_lane; int s0; int s1;
      int p0; int p1; int pd; int ior; int dior; int first_ior; int done;
   } exp_t;

   exp_t sb[$];
   int   tests = 0, fails = 0;
   int   off0, off1, offd;
   bit   stuck1;
   int   gcyc = 0, cyc = 0;
   int   last0, last1, lastd;
   bit   prev_slip;
   int   p0, p1, pd, ior_n, dior_n, first_ior;

   task automatic chk(input string name, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", name, obs, exp);
      end
   endtask

   function automatic logic [5:0] rot6(input logic [5:0] v, input int n);
      logic [5:0] r = v;
      for (int i = 0; i < n; i++) r = {r[4:0], r[5]};
      return r;
   endfunction

   function automatic logic [7:0] rot8(input logic [7:0] v, input int n);
      logic [7:0] r = v;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   function automatic exp_t mk(input int lk, input int fl, input int fln, input int s0,
                               input int s1, input int pdn, input int done);
      exp_t e;
      e.lock = lk; e.fl = fl; e.fail_lane = fln; e.s0 = s0; e.s1 = s1;
      e.p0 = s0; e.p1 = s1; e.pd = pdn; e.ior = 4; e.dior = DIOR; e.first_ior = 1;
      e.done = done;
      return e;
   endfunction

   task automatic drive_bits();
      adc_bits   = {stuck1 ? 6'h00 : rot6(6'b001111, off1), rot6(6'b110000, off0)};
      discr_bits = rot8(8'hF0, offd);
   endtask

   // One clock; observe #1 after the edge, update the deserializer model on bitslip pulses.
   task automatic step();
      bit cur_slip;
      @(posedge lclk);
      #1;
      gcyc++;
      cyc++;
      cur_slip = (adc_bitslip != 2'b00) || discr_bitslip;
      chk("slip_with_ioreset", int'(cur_slip && ((adc_io_reset != 2'b00) || discr_io_reset)), 0);
      if (cur_slip) chk("slip_back_to_back", int'(prev_slip), 0);
      if (adc_bitslip[0]) begin
         chk("slip0_spacing", int'(gcyc - last0 >= 9), 1);
         last0 = gcyc; p0++; off0 = (off0 + 5) % 6;
      end
      if (adc_bitslip[1]) begin
         chk("slip1_spacing", int'(gcyc - last1 >= 9), 1);
         last1 = gcyc; p1++; off1 = (off1 + 5) % 6;
      end
      if (discr_bitslip) begin
         chk("slipd_spacing", int'(gcyc - lastd >= 9), 1);
         lastd = gcyc; pd++; offd = (offd + 7) % 8;
      end
      if (adc_io_reset == 2'b11) begin
         ior_n++;
         if (first_ior == 0) first_ior = cyc;
      end
      if (discr_io_reset) dior_n++;
      prev_slip = cur_slip;
      drive_bits();
   endtask

   task automatic begin_run(input int o0, input int o1, input int od, input bit st1);
      off0 = o0; off1 = o1; offd = od; stuck1 = st1;
      p0 = 0; p1 = 0; pd = 0; ior_n = 0; dior_n = 0; first_ior = 0; cyc = 0;
      last0 = -1000; last1 = -1000; lastd = -1000;
      drive_bits();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run(input int o0, input int o1, input int od, input bit st1,
                      input int restart_at, input exp_t e);
      exp_t x;
      sb.push_back(e);
      begin_run(o0, o1, od, st1);
      chk("busy_after_start", int'(busy), 1);
      chk("locked_after_start", int'(locked), 0);
      chk("fail_after_start", int'(fail), 0);
      while (busy && cyc < 400) begin
         if (cyc == restart_at) start = 1'b1;
         step();
         start = 1'b0;
      end
      chk("run_timeout", int'(busy), 0);
      x = sb.pop_front();
      chk("locked", int'(locked), x.lock);
      chk("fail", int'(fail), x.fl);
      chk("fail_lane", int'(fail_lane), x.fail_lane);
      chk("slip_count_0", int'(slip_count_0), x.s0);
      chk("slip_count_1", int'(slip_count_1), x.s1);
      chk("pulses_lane0", p0, x.p0);
      chk("pulses_lane1", p1, x.p1);
      chk("pulses_discr", pd, x.pd);
      chk("io_reset_cycles", ior_n, x.ior);
      chk("discr_io_reset_cycles", dior_n, x.dior);
      chk("io_reset_first_cycle", first_ior, x.first_ior);
      chk("done_cycle", cyc, x.done);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_io_reset"}, int'({adc_io_reset, discr_io_reset}), 0);
      chk({tag, "_bitslip"}, int'({adc_bitslip, discr_bitslip}), 0);
      chk({tag, "_status"}, int'({busy, locked, fail}), 0);
      chk({tag, "_fail_lane"}, int'(fail_lane), 0);
      chk({tag, "_slips"}, int'({slip_count_1, slip_count_0}), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      off0 = 0; off1 = 0; offd = 0; stuck1 = 1'b0;
      last0 = -1000; last1 = -1000; lastd = -1000; prev_slip = 1'b0;
      drive_bits();
      repeat (3) step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();
      chk_all_zero("idle");

      // Aligned input: lock at cycle 29.
      run(0, 0, 0, 1'b0, -1, mk(1, 0, 0, 0, 0, 0, 29));
      // Start while LOCKED retrains; a start pulse during SETTLE is ignored.
      run(0, 0, 0, 1'b0, 6, mk(1, 0, 0, 0, 0, 0, 29));
      // Lane 0 two positions off.
      run(2, 0, 0, 1'b0, -1, mk(1, 0, 0, 2, 0, 0, 49));
      // Lane 1 stuck at zero exhausts its slips.
      run(0, 0, 0, 1'b1, -1, mk(0, 1, 2, 0, 6, 0, 74));

      // Reset the cycle after a slip pulse, then retrain from scratch.
      begin_run(0, 0, 0, 1'b1);
      while (adc_bitslip == 2'b00 && cyc < 100) step();
      chk("slip_seen_before_reset", int'(adc_bitslip), 2);
      step();
      rst = 1'b1;
      step();
      chk_all_zero("mid_reset");
      rst = 1'b0;
      step();
      chk("idle_after_reset_busy", int'(busy), 0);
      run(0, 0, 0, 1'b0, -1, mk(1, 0, 0, 0, 0, 0, 29));

`ifdef DISCR_ALIGN_EN
      // Discriminator lane three positions off, ADC lanes aligned.
      run(0, 0, 3, 1'b0, -1, mk(1, 0, 0, 0, 0, 3, 59));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/adc_discr_align_ctrl.md
Name: adc_discr_align_ctrl

Overview:
Link-training controller sitting directly downstream of the per-channel ADC/discriminator deserializer stage, in the lclk domain. Consumes the deserialized ADC lane words (and optionally the discriminator word) while the front end emits a fixed training pattern. Drives the deserializer io_reset and per-lane bitslip controls until each lane matches the pattern for a run of consecutive cycles, then reports lock or failure per lane.

Parameters:
TRAIN_PATTERN, 12'h3F0, expected adc_bits during training; [5:0] lane 0 (6'b110000), [11:6] lane 1 (6'b001111); each 6-bit half must be distinct under every nonzero rotation
DISCR_PATTERN, 8'hF0, expected discr_bits during training (used only with DISCR_ALIGN_EN)
IO_RESET_CYCLES, 4, cycles io_reset is held high at start of training (>=1)
SETTLE_CYCLES, 8, wait after io_reset release or after any bitslip before comparing (>=3)
MATCH_COUNT, 16, consecutive all-lane matches required for lock (>=1)
MAX_SLIPS, 6, bitslips allowed per lane before declaring failure (1..7)

Ports:
lclk  in  1  parallel-word clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to (re)train
adc_bits  in  12  deserialized ADC word, {lane1, lane0}
discr_bits  in  8  deserialized discriminator word
adc_io_reset  out  2  deserializer reset, one bit per ADC lane
adc_bitslip  out  2  one-cycle bitslip pulse per ADC lane
discr_io_reset  out  1  discriminator deserializer reset
discr_bitslip  out  1  discriminator bitslip pulse
busy  out  1  training in progress
locked  out  1  all enabled lanes aligned
fail  out  1  training aborted
fail_lane  out  3  lanes that exhausted MAX_SLIPS: bit0 lane0, bit1 lane1, bit2 discr
slip_count_0  out  3  bitslips issued on lane 0 in current run
slip_count_1  out  3  bitslips issued on lane 1 in current run

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0. rst overrides everything, including mid-training; io_reset/bitslip drop at the next edge.
- States: IDLE, IORST, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- start sampled in IDLE/LOCKED/FAIL -> IORST; clears locked, fail, fail_lane, slip counts, match counter; busy=1 next cycle. start in any other state is ignored.
- IORST: adc_io_reset=2'b11 for exactly IO_RESET_CYCLES cycles -> SETTLE.
- SETTLE: all controls low for SETTLE_CYCLES cycles -> CHECK.
- CHECK: per cycle, compare each enabled lane with its pattern slice.
  - all match: match_cnt+1; on reaching MATCH_COUNT -> LOCKED.
  - any mismatch: match_cnt=0. If any mismatching lane has slip count == MAX_SLIPS -> FAIL, fail_lane = set of such lanes. Otherwise -> SLIP.
- SLIP: one cycle; bitslip high only for lanes that mismatched in the final CHECK cycle; their slip counts +1 -> SETTLE.
- LOCKED: locked=1, busy=0; no further comparison. FAIL: fail=1, busy=0.
- Guarantees: bitslip is never high on two consecutive cycles; consecutive pulses on a lane are >= SETTLE_CYCLES+1 cycles apart; bitslip and io_reset are never high together.
- Latency with aligned input: start sampled at edge 0; io_reset high during cycles 1..IO_RESET_CYCLES; locked rises at cycle IO_RESET_CYCLES+SETTLE_CYCLES+MATCH_COUNT+1 (29 with defaults).
- Slip counters saturate at MAX_SLIPS; no wrap.

Optional Feature:
DISCR_ALIGN_EN: when defined, the discriminator lane is trained alongside the ADC lanes: discr_io_reset follows adc_io_reset, it is compared with DISCR_PATTERN, gets its own slip counter and discr_bitslip, and is included in the lock and fail conditions (fail_lane[2]). When undefined: discr_io_reset=0, discr_bitslip=0, fail_lane[2]=0, discr_bits ignored.

Test Plan:
- adc_bits held at 12'h3F0, start pulse -> adc_io_reset=2'b11 for cycles 1-4, no bitslip, locked=1 at cycle 29, slip counts 0, busy low from cycle 29.
- Bench rotates lane 0 (initial offset 2, one position per bitslip), lane 1 aligned -> adc_bitslip=2'b01 pulsed exactly twice >=9 cycles apart, slip_count_0=2, slip_count_1=0, locked=1.
- Lane 1 stuck at 6'h00 -> six 2'b10 pulses, then fail=1, fail_lane=3'b010, locked=0, busy=0.
- rst asserted the cycle after a SLIP pulse -> next cycle all outputs 0; new start performs a full run from IORST.
- start during SETTLE ignored (no extra io_reset); start while LOCKED -> locked drops next cycle, io_reset reasserted for 4 cycles.
- DISCR_ALIGN_EN defined, discr offset 3, ADC lanes aligned -> discr_bitslip pulsed 3 times, locked only after all three lanes match 16 consecutive cycles.
